// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit and the processor MEM stage.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    // dsize encoding is bytes-1; 2 has no meaning and is rejected
    localparam logic [0:1] SZ_BYTE    = 2'd0;
    localparam logic [0:1] SZ_HALF    = 2'd1;
    localparam logic [0:1] SZ_ILLEGAL = 2'd2;
    localparam logic [0:1] SZ_WORD    = 2'd3;

    function automatic logic size_misaligned(input logic [0:1] size, input logic [0:1] addr_lsb);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_WORD: bad = (addr_lsb != 2'b00);
            SZ_HALF: bad = addr_lsb[1];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword from big-endian read data and sign- or zero-extends it.
module load_extend
    import dmem_lsu_pkg::*;
(
    input  logic [0:31] rData,
    input  logic [0:1]  size,
    input  logic        sign_ext,
    output logic [0:31] data
);

    logic fill;

    always_comb begin
        fill = sign_ext & rData[0];
        data = rData;
        case (size)
            SZ_BYTE: data = {{24{fill}}, rData[0:7]};
            SZ_HALF: data = {{16{fill}}, rData[0:15]};
            default: data = rData;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-request load/store unit between the core MEM stage and a combinational data memory.
//   state     | meaning
//   ST_IDLE   | ready for a request; request fields captured on acceptance
//   ST_ACCESS | memory addressed for one cycle; store commits, load data captured
//   ST_RESP   | response held until the core takes it
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int MEM_SIZE = 32768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [0:1]  req_size,
    input  logic        req_signed,
    input  logic [0:31] req_addr,
    input  logic [0:31] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [0:31] resp_rdata,
    output logic        resp_err,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_wData,
    output logic        mem_writeEnable,
    output logic [0:1]  mem_dsize,
    input  logic [0:31] mem_rData
);

    lsu_state_t state, state_nxt;

    logic [0:31] addr_q;
    logic [0:31] wdata_q;
    logic [0:1]  size_q;
    logic        store_q;
    logic        sign_q;
    logic        err_q;
    logic [0:31] rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        req_err;
    logic [32:0] end_addr;
    logic [0:31] ext_data;

    // 33-bit sum so an address near 2^32 that wraps still counts as out of range
    assign end_addr = {1'b0, req_addr} + {31'b0, req_size};
    assign req_err  = (req_size == SZ_ILLEGAL)
                    | size_misaligned(req_size, req_addr[30:31])
                    | (end_addr >= 33'(MEM_SIZE));

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_WORD;
            store_q <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            store_q <= req_store;
            sign_q  <= req_signed;
            err_q   <= req_err;
        end
    end

    load_extend u_load_extend (
        .rData    (mem_rData),
        .size     (size_q),
        .sign_ext (sign_q),
        .data     (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
        end else if (state == ST_ACCESS) begin
            rdata_q    <= (store_q || err_q) ? '0 : ext_data;
            resp_err_q <= err_q;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;

    // The request registers drive the memory directly, so they hold between accesses.
    assign mem_addr        = addr_q;
    assign mem_wData       = wdata_q;
    assign mem_dsize       = size_q;
    // reset gates the strobe so a store caught mid-access never reaches memory
    assign mem_writeEnable = (state == ST_ACCESS) && store_q && !err_q && !reset;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a 16 KiB big-endian byte memory behind the memory port.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int DMEM_SIZE = 16384;
    localparam int NV        = 23;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [0:1]  req_size;
    logic        req_signed;
    logic [0:31] req_addr;
    logic [0:31] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:31] resp_rdata;
    logic        resp_err;
    logic [0:31] mem_addr;
    logic [0:31] mem_wData;
    logic        mem_writeEnable;
    logic [0:1]  mem_dsize;
    logic [0:31] mem_rData;

    dmem_lsu #(.MEM_SIZE(DMEM_SIZE)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_addr        (mem_addr),
        .mem_wData       (mem_wData),
        .mem_writeEnable (mem_writeEnable),
        .mem_dsize       (mem_dsize),
        .mem_rData       (mem_rData)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:DMEM_SIZE-1];
    logic [13:0] idx;
    int          we_total = 0;

    always_comb begin
        idx       = mem_addr[18:31];
        mem_rData = {mem[idx], mem[idx + 14'd1], mem[idx + 14'd2], mem[idx + 14'd3]};
    end

    always @(posedge clk) begin
        if (mem_writeEnable) begin
            we_total <= we_total + 1;
            case (mem_dsize)
                SZ_BYTE: mem[idx] <= mem_wData[24:31];
                SZ_HALF: begin
                    mem[idx]         <= mem_wData[16:23];
                    mem[idx + 14'd1] <= mem_wData[24:31];
                end
                default: begin
                    mem[idx]         <= mem_wData[0:7];
                    mem[idx + 14'd1] <= mem_wData[8:15];
                    mem[idx + 14'd2] <= mem_wData[16:23];
                    mem[idx + 14'd3] <= mem_wData[24:31];
                end
            endcase
        end
    end

    typedef struct {
        string       name;
        logic        store;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          we;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          we_end;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(string n, logic st, logic [1:0] sz, logic sg, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] rd, logic er, int we);
        vec_t v;
        v.name = n; v.store = st; v.size = sz; v.sgn = sg; v.addr = a;
        v.wdata = wd; v.rdata = rd; v.err = er; v.we = we;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, " req_ready"},       32'(req_ready),       32'd1);
        check({tag, " resp_valid"},      32'(resp_valid),      32'd0);
        check({tag, " resp_err"},        32'(resp_err),        32'd0);
        check({tag, " resp_rdata"},      resp_rdata,           32'd0);
        check({tag, " mem_writeEnable"}, 32'(mem_writeEnable), 32'd0);
        check({tag, " mem_addr"},        mem_addr,             32'd0);
        check({tag, " mem_wData"},       mem_wData,            32'd0);
        check({tag, " mem_dsize"},       32'(mem_dsize),       32'd3);
    endtask

    // Presents one request, lets it be accepted, and returns at the ACCESS-cycle negedge.
    task automatic drive(vec_t v, bit push);
        exp_t e;
        @(negedge clk);
        check({v.name, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = v.store;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        if (push) begin
            e.name = v.name; e.rdata = v.rdata; e.err = v.err; e.we_end = we_total + v.we;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        req_store  = ~v.store;
        req_size   = 2'($urandom_range(0, 3));
        req_signed = ~v.sgn;
        req_addr   = $urandom();
        req_wdata  = $urandom();
        check({v.name, " mem_addr"},  mem_addr,            v.addr);
        check({v.name, " mem_dsize"}, 32'(mem_dsize),      32'(v.size));
        check({v.name, " mem_wData"}, mem_wData,           v.wdata);
        check({v.name, " mem_we"},    32'(mem_writeEnable), 32'(v.store && !v.err));
    endtask

    // Waits for the response, optionally stalls it, then pops and compares against the scoreboard.
    task automatic wait_resp(int hold, bit poke);
        int   waited;
        exp_t e;
        waited     = 0;
        resp_ready = (hold == 0);
        while (!resp_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_empty: response with no expected entry");
            resp_ready = 1'b1;
            return;
        end
        e = sb.pop_front();
        if (!resp_valid) begin
            checks++; failures++;
            $display("FAIL %s timeout: resp_valid=0 after %0d cycles, required 1", e.name, waited);
            resp_ready = 1'b1;
            return;
        end
        check({e.name, " latency"}, 32'(waited), 32'd1);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1'b1;
                req_store = 1'b1;
                req_size  = SZ_WORD;
                req_addr  = 32'h2000;
                req_wdata = 32'h0;
            end
            @(negedge clk);
            check({e.name, " hold resp_valid"}, 32'(resp_valid), 32'd1);
            check({e.name, " hold resp_rdata"}, resp_rdata,      e.rdata);
            check({e.name, " hold resp_err"},   32'(resp_err),   32'(e.err));
            check({e.name, " hold req_ready"},  32'(req_ready),  32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        check({e.name, " rdata"},    resp_rdata,    e.rdata);
        check({e.name, " err"},      32'(resp_err), 32'(e.err));
        check({e.name, " we_count"}, 32'(we_total), 32'(e.we_end));
    endtask

    initial begin
        vec_t v;
        vecs[0]  = mk("st_w_2000",    1, 3, 0, 32'h2000,     32'hDEADBEEF, 32'h0,        0, 1);
        vecs[1]  = mk("ld_w_2000",    0, 3, 0, 32'h2000,     32'h0,        32'hDEADBEEF, 0, 0);
        vecs[2]  = mk("st_b_2001",    1, 0, 0, 32'h2001,     32'h00000080, 32'h0,        0, 1);
        vecs[3]  = mk("ld_b_s_2001",  0, 0, 1, 32'h2001,     32'h0,        32'hFFFFFF80, 0, 0);
        vecs[4]  = mk("ld_b_u_2001",  0, 0, 0, 32'h2001,     32'h0,        32'h00000080, 0, 0);
        vecs[5]  = mk("st_h_2002",    1, 1, 0, 32'h2002,     32'h1234ABCD, 32'h0,        0, 1);
        vecs[6]  = mk("ld_h_u_2002",  0, 1, 0, 32'h2002,     32'h0,        32'h0000ABCD, 0, 0);
        vecs[7]  = mk("ld_h_s_2002",  0, 1, 1, 32'h2002,     32'h0,        32'hFFFFABCD, 0, 0);
        vecs[8]  = mk("ld_w_after_h", 0, 3, 0, 32'h2000,     32'h0,        32'hDE80ABCD, 0, 0);
        vecs[9]  = mk("ld_w_mis",     0, 3, 0, 32'h2002,     32'h0,        32'h0,        1, 0);
        vecs[10] = mk("st_h_mis",     1, 1, 0, 32'h2001,     32'hFFFFFFFF, 32'h0,        1, 0);
        vecs[11] = mk("st_size2",     1, 2, 0, 32'h2000,     32'hFFFFFFFF, 32'h0,        1, 0);
        vecs[12] = mk("ld_w_3ffe",    0, 3, 0, 32'h3FFE,     32'h0,        32'h0,        1, 0);
        vecs[13] = mk("st_w_mis",     1, 3, 0, 32'h2003,     32'h00000000, 32'h0,        1, 0);
        vecs[14] = mk("ld_w_nowrite", 0, 3, 0, 32'h2000,     32'h0,        32'hDE80ABCD, 0, 0);
        vecs[15] = mk("st_w_3ffc",    1, 3, 0, 32'h3FFC,     32'hCAFEF00D, 32'h0,        0, 1);
        vecs[16] = mk("ld_w_3ffc",    0, 3, 1, 32'h3FFC,     32'h0,        32'hCAFEF00D, 0, 0);
        vecs[17] = mk("ld_b_s_3fff",  0, 0, 1, 32'h3FFF,     32'h0,        32'h0000000D, 0, 0);
        vecs[18] = mk("ld_b_4000",    0, 0, 0, 32'h4000,     32'h0,        32'h0,        1, 0);
        vecs[19] = mk("ld_h_s_3ffe",  0, 1, 1, 32'h3FFE,     32'h0,        32'hFFFFF00D, 0, 0);
        vecs[20] = mk("ld_w_wrap",    0, 3, 0, 32'hFFFFFFFC, 32'h0,        32'h0,        1, 0);
        vecs[21] = mk("ld_h_s_2000",  0, 1, 1, 32'h2000,     32'h0,        32'hFFFFDE80, 0, 0);
        vecs[22] = mk("ld_b_s_2002",  0, 0, 1, 32'h2002,     32'h0,        32'hFFFFFFAB, 0, 0);

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i], 1'b1);
            wait_resp(0, 1'b0);
        end

        // stalled response with a competing request that must be ignored
        drive(mk("ld_w_hold", 0, 3, 0, 32'h2000, 32'h0, 32'hDE80ABCD, 0, 0), 1'b1);
        wait_resp(5, 1'b1);
        drive(mk("ld_w_posthold", 0, 3, 0, 32'h2000, 32'h0, 32'hDE80ABCD, 0, 0), 1'b1);
        wait_resp(0, 1'b0);

        // reset lands on the ACCESS cycle of a store
        v = mk("st_w_reset", 1, 3, 0, 32'h2000, 32'h11223344, 32'h0, 0, 1);
        begin
            int we_before;
            we_before = we_total;
            drive(v, 1'b0);
            reset = 1'b1;
            #1;
            check("reset_access mem_we", 32'(mem_writeEnable), 32'd0);
            @(negedge clk);
            check_reset_outputs("reset_access");
            check("reset_access mem", {mem[14'h2000], mem[14'h2001], mem[14'h2002], mem[14'h2003]},
                  32'hDE80ABCD);
            check("reset_access we_count", 32'(we_total), 32'(we_before));
            reset = 1'b0;
        end
        drive(mk("ld_w_postreset", 0, 3, 0, 32'h2000, 32'h0, 32'hDE80ABCD, 0, 0), 1'b1);
        wait_resp(0, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
